// File: rtl/ddr_in_deser.sv
// DDR input receiver: captures one serial pin on both clock edges, retimes each
// rise/fall bit pair into the rising-edge domain and emits sync-aligned words.
module ddr_in_deser #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(8'hD5)
) (
  input  logic             C,
  input  logic             R,
  input  logic             CE,
  input  logic             D,
  input  logic             RESYNC,
  output logic [WIDTH-1:0] Q,
  output logic             QV,
  output logic             LOCKED
);

  localparam int PAIRS    = WIDTH / 2;
  localparam int FILL_MAX = PAIRS + 1;
  localparam int FW       = $clog2(FILL_MAX + 1);
  localparam int CW       = $clog2(PAIRS);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             d_r;
  logic             d_f;
  logic             ce_d;
  logic [WIDTH-2:0] hist;
  logic [WIDTH:0]   h_next;
  logic [FW-1:0]    fill;
  logic [FW-1:0]    fill_next;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic             phase;
  logic             phase_next;
  logic [WIDTH-1:0] q_next;
  logic             qv_next;
  logic             sync_even;
  logic             sync_odd;

  // Only the bits that survive the next shift are stored; the full
  // WIDTH+1-bit history is always the freshly updated h_next.
  assign h_next    = {hist, d_r, d_f};
  assign fill_next = (ce_d && (fill != FW'(FILL_MAX))) ? fill + 1'b1 : fill;
  assign sync_even = (h_next[WIDTH-1:0] == SYNC_WORD);
  assign sync_odd  = (h_next[WIDTH:1]   == SYNC_WORD);
  assign LOCKED    = (state == LOCK);

  always_ff @(negedge C) begin
    d_f <= D;
  end

  always_ff @(posedge C) begin
    if (R) begin
      d_r   <= 1'b0;
      ce_d  <= 1'b0;
      hist  <= '0;
      fill  <= '0;
      cnt   <= '0;
      phase <= 1'b0;
      state <= HUNT;
      Q     <= '0;
      QV    <= 1'b0;
    end else begin
      d_r   <= D;
      ce_d  <= CE;
      if (ce_d) begin
        hist <= h_next[WIDTH-2:0];
      end
      fill  <= fill_next;
      cnt   <= cnt_next;
      phase <= phase_next;
      state <= state_next;
      Q     <= q_next;
      QV    <= qv_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    phase_next = phase;
    q_next     = Q;
    qv_next    = 1'b0;
    if (RESYNC) begin
      state_next = HUNT;
      cnt_next   = '0;
    end else if (ce_d) begin
      case (state)
        HUNT: begin
          // Even alignment wins when both candidates match.
          if (fill_next == FW'(FILL_MAX)) begin
            if (sync_even) begin
              state_next = LOCK;
              phase_next = 1'b0;
              cnt_next   = '0;
            end else if (sync_odd) begin
              state_next = LOCK;
              phase_next = 1'b1;
              cnt_next   = '0;
            end
          end
        end
        LOCK: begin
          if (cnt == CW'(PAIRS - 1)) begin
            cnt_next = '0;
            qv_next  = 1'b1;
            q_next   = phase ? h_next[WIDTH:1] : h_next[WIDTH-1:0];
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

endmodule

// File: doc/ddr_in_deser.md
# ddr_in_deser

DDR input receiver and deserializer: the receive end of the team's DDR output flip-flop links. It samples a single serial data pin on both edges of `C` and retimes each rising/falling bit pair into the rising-edge domain. It locks onto a sync word at either bit phase and emits aligned `WIDTH`-bit words with a one-cycle valid strobe. It sits directly behind the input pad, ahead of any word-level framing logic.

## Interface
- `WIDTH`, 8, output word width; even, 4..16.
- `SYNC_WORD`, 8'hD5, `WIDTH`-bit alignment pattern, first-received bit in the MSB; must not be all-zero.
- `C`  in  1  clock; data is sampled on both edges, all state updates on the rising edge.
- `R`  in  1  reset, synchronous and active-high, sampled on the rising edge of `C`.
- `CE`  in  1  clock enable; qualifies the bit pair whose rising-edge bit is sampled at the same edge.
- `D`  in  1  serial DDR data from the pad.
- `RESYNC`  in  1  single-cycle request to drop lock and hunt for `SYNC_WORD` again.
- `Q`  out  `WIDTH`  aligned received word, first-received bit in the MSB.
- `QV`  out  1  one-cycle strobe; `Q` is new this cycle.
- `LOCKED`  out  1  high while aligned.

## Operation
- **Capture**
  - `d_r` samples `D` on the rising edge at t_k; `d_f` samples `D` on the following falling edge; `d_f` has no reset.
  - `CE` at t_k is registered alongside `d_r` as `ce_d`.
  - The pair is {`d_r`, `d_f`}, rise bit first. This matches the transmitter, which sends D0 in the high phase and D1 in the low phase.
- **History**
  - `h[WIDTH:0]` updates at t_k+1 only if `ce_d`: `h <= {h[WIDTH-2:0], d_r, d_f}`.
  - Even candidate word = `h[WIDTH-1:0]`; odd candidate word = `h[WIDTH:1]`.
  - A fill counter saturates at `WIDTH/2+1` accepted pairs. Sync compares are inhibited until it saturates.
- **States** (reset state HUNT)
  - HUNT
    - On each accepted pair with fill saturated, compare the updated history against `SYNC_WORD`.
    - Even match: go to LOCK with phase=even and pair count=0.
    - Otherwise, odd match: go to LOCK with phase=odd and pair count=0.
    - If both match, even wins.
    - No `QV` in HUNT. The sync word itself is never emitted.
  - LOCK
    - Each accepted pair increments the pair count, modulo `WIDTH/2`.
    - When the count wraps from `WIDTH/2-1` to 0, register `Q` from the updated history: `h[WIDTH-1:0]` if phase is even, `h[WIDTH:1]` if odd. Pulse `QV`.
    - `SYNC_WORD` arriving as payload is emitted as ordinary data. No re-check is done in LOCK.
  - `RESYNC` high at any rising edge: go to HUNT, clear pair count, `LOCKED`=0, `QV`=0. History and fill are kept.
- **Priority:** `R` > `RESYNC` > word completion or sync match.
- **Reset values:** `Q`=0, `QV`=0, `LOCKED`=0, `h`=0, fill=0, pair count=0, `ce_d`=0, phase=even.
  - Reset mid-word discards the partial word.
  - The pair sampled during the cycle in which `R` deasserts is discarded, because `ce_d` is 0.

## Timing
- **Data latency:** for the last pair of a word, the rise bit is sampled at t_k and the fall bit at t_k+½. `Q`/`QV` are registered at t_k+1 and visible during the cycle after t_k+1.
- `LOCKED` rises at the same edge as the history update that completes the sync match.
- The first payload `QV` follows exactly `WIDTH/2` accepted pairs after that edge.
- **`CE` low:** the pair is dropped, counters hold, `QV` stays low, and `Q` holds its value. Words complete late by the number of rejected cycles.
- `QV` is never high on two consecutive cycles when `WIDTH` ≥ 4, unless `CE` is continuously high and `WIDTH`=2 (not permitted).
- **Lock throughput:** one word every `WIDTH/2` cycles with `CE` held high.

## Test plan
Default parameters (`WIDTH`=8, `SYNC_WORD`=8'hD5) unless stated.

- **Reset:** hold `R` high for 2 cycles in the middle of a locked word -> `Q`=0, `QV`=0, `LOCKED`=0 on the next cycle. A word in progress is never emitted.
- **Even lock:** after 5 zero pairs, send D5, 3C, A1 as 4 pairs each with `CE`=1 -> `LOCKED` rises the cycle after D5's last pair. `QV` pulses with `Q`=8'h3C, then 4 cycles later with `Q`=8'hA1. No `QV` for D5.
- **Odd lock:** send the same stream preceded by one extra bit (fall-phase 1) -> phase=odd, `LOCKED`=1, `Q`=8'h3C then 8'hA1.
- **`CE` gating:** drop `CE` for 3 cycles after the second pair of 3C -> `QV` delayed exactly 3 cycles, `Q`=8'h3C intact.
- **`RESYNC` collision:** assert `RESYNC` on the edge that completes A1 -> no `QV`, `LOCKED`=0. The next D5 relocks and the following word is emitted.
- **Payload sync:** while locked, send D5 as data -> `QV` with `Q`=8'hD5, and `LOCKED` stays 1.
